fg_move_scheduler: RTL and testbench



---
 rtl/fg_move_scheduler.sv | 245 ++++++++++++++++++++++++
 tb/tb_fg_move_scheduler.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fg_move_scheduler.sv
// Lane-move sequencer: buffers obstacle rows, decodes each to a gap lane, then emits lateral steps and one crossing action.
// Define FG_ROW_CHECK_EN to flag and drop malformed wall rows; the default build has no row check and ties err low.

module fg_move_scheduler #(
    parameter int FIFO_DEPTH = 4,
    parameter int PTR_W      = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [2:0] guy,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    input  logic [1:0] in0,
    input  logic [1:0] in1,
    input  logic [1:0] in2,
    input  logic [1:0] in3,
    input  logic [1:0] in4,
    input  logic [1:0] in5,
    input  logic [1:0] in6,
    input  logic [1:0] in7,
    output logic       out_valid,
    output logic [1:0] out,
    output logic [2:0] pos,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_MOVE, S_CROSS} state_e;

    typedef enum logic [1:0] {
        MV_WALK  = 2'd0,
        MV_RIGHT = 2'd1,
        MV_LEFT  = 2'd2,
        MV_JUMP  = 2'd3
    } move_e;

    localparam logic [1:0] LANE_EMPTY = 2'd0;
    localparam logic [1:0] LANE_LOW   = 2'd1;
    localparam logic [1:0] LANE_WALL  = 2'd3;

    typedef struct packed {
        logic        last;
        logic [15:0] lanes;
    } row_t;

    function automatic logic [1:0] lane_of(input logic [15:0] lanes, input logic [2:0] idx);
        return lanes[{idx, 1'b0} +: 2];
    endfunction

    function automatic move_e cross_move(input logic [1:0] lane_type);
        return (lane_type == LANE_LOW) ? MV_JUMP : MV_WALK;
    endfunction

    // ------------------------------------------------------------------
    // Row FIFO
    // ------------------------------------------------------------------
    row_t             mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             full, empty, push, pop;
    row_t             in_row, head;

    state_e           state_q, state_d;
    logic [2:0]       pos_q, pos_d;
    logic [2:0]       gap_q, gap_d;
    logic [1:0]       type_q, type_d;
    logic             last_q, last_d;
    logic             out_valid_q, out_valid_d;
    move_e            out_q, out_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    assign in_row   = {in_last, in7, in6, in5, in4, in3, in2, in1, in0};
    assign head     = mem_q[rd_ptr_q];
    assign full     = (count_q == (PTR_W+1)'(FIFO_DEPTH));
    assign empty    = (count_q == '0);
    assign in_ready = (state_q != S_IDLE) && !full;
    assign push     = in_valid && in_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    end

    // NOTE: row storage is not reset; flushing the pointers and count makes stale entries unreachable.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_row;
        end
    end

    // ------------------------------------------------------------------
    // Head-row decode
    // ------------------------------------------------------------------
    logic       any_wall;
    logic [3:0] open_cnt;
    logic [2:0] low_gap;
    logic [2:0] dec_gap;
    logic [1:0] dec_type;
    logic       dec_bad;

    // NOTE: every variable is given a default before any branch, so no path can infer a latch.
    always_comb begin
        any_wall = 1'b0;
        open_cnt = '0;
        low_gap  = '0;
        // Scanning downward leaves the lowest-index open lane in low_gap.
        for (int i = 7; i >= 0; i--) begin
            if (head.lanes[2*i +: 2] == LANE_WALL) begin
                any_wall = 1'b1;
            end else begin
                open_cnt = open_cnt + 4'd1;
                low_gap  = 3'(i);
            end
        end

        dec_gap  = pos_q;
        dec_type = lane_of(head.lanes, pos_q);
        dec_bad  = 1'b0;
        if (any_wall) begin
`ifdef FG_ROW_CHECK_EN
            dec_bad  = (open_cnt != 4'd1);
            dec_gap  = low_gap;
            dec_type = lane_of(head.lanes, low_gap);
`else
            if (open_cnt != 4'd0) begin
                dec_gap  = low_gap;
                dec_type = lane_of(head.lanes, low_gap);
            end else begin
                dec_type = LANE_EMPTY;
            end
`endif
        end
    end

    // ------------------------------------------------------------------
    // Sequencer: registered outputs describe the move shown this cycle
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        pos_d       = pos_q;
        gap_d       = gap_q;
        type_d      = type_q;
        last_d      = last_q;
        out_valid_d = 1'b0;
        out_d       = MV_WALK;
        done_d      = 1'b0;
        err_d       = 1'b0;
        pop         = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    pos_d   = guy;
                    state_d = S_FETCH;
                end
            end

            S_FETCH: begin
                if (!empty) begin
                    pop    = 1'b1;
                    gap_d  = dec_gap;
                    type_d = dec_type;
                    last_d = head.last;
                    if (dec_bad) begin
                        err_d   = 1'b1;
                        done_d  = head.last;
                        state_d = head.last ? S_IDLE : S_FETCH;
                    end else if (dec_gap != pos_q) begin
                        state_d     = S_MOVE;
                        out_valid_d = 1'b1;
                        out_d       = (dec_gap > pos_q) ? MV_RIGHT : MV_LEFT;
                        pos_d       = (dec_gap > pos_q) ? pos_q + 3'd1 : pos_q - 3'd1;
                    end else begin
                        state_d     = S_CROSS;
                        out_valid_d = 1'b1;
                        out_d       = cross_move(dec_type);
                    end
                end
            end

            S_MOVE: begin
                out_valid_d = 1'b1;
                if (pos_q == gap_q) begin
                    state_d = S_CROSS;
                    out_d   = cross_move(type_q);
                end else begin
                    out_d = (gap_q > pos_q) ? MV_RIGHT : MV_LEFT;
                    pos_d = (gap_q > pos_q) ? pos_q + 3'd1 : pos_q - 3'd1;
                end
            end

            S_CROSS: begin
                done_d  = last_q;
                state_d = last_q ? S_IDLE : S_FETCH;
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every flop samples the pre-edge values together.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            pos_q       <= '0;
            gap_q       <= '0;
            type_q      <= '0;
            last_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_q       <= MV_WALK;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            pos_q       <= pos_d;
            gap_q       <= gap_d;
            type_q      <= type_d;
            last_q      <= last_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign pos       = pos_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_fg_move_scheduler.sv
// Scoreboard bench for fg_move_scheduler: a lane-level reference model queues expected moves/events at row acceptance.
// Directed scenarios cover reset, latency, back-pressure, malformed rows and ignored start; random sessions follow.

module tb_fg_move_scheduler;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  guy;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [15:0] row_drv;
    logic        out_valid;
    logic [1:0]  out;
    logic [2:0]  pos;
    logic        busy;
    logic        done;
    logic        err;

    fg_move_scheduler #(.FIFO_DEPTH(4), .PTR_W(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .guy       (guy),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .in0       (row_drv[1:0]),
        .in1       (row_drv[3:2]),
        .in2       (row_drv[5:4]),
        .in3       (row_drv[7:6]),
        .in4       (row_drv[9:8]),
        .in5       (row_drv[11:10]),
        .in6       (row_drv[13:12]),
        .in7       (row_drv[15:14]),
        .out_valid (out_valid),
        .out       (out),
        .pos       (pos),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit       is_evt;
        bit [1:0] out;
        bit [2:0] pos;
        bit       done;
        bit       err;
    } exp_t;

    exp_t exp_q[$];
    int   checks       = 0;
    int   errors       = 0;
    int   model_pos    = 0;
    int   stall_cycles = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input bit is_evt, input bit [1:0] o, input int p, input bit d, input bit e);
        exp_t x;
        x.is_evt = is_evt;
        x.out    = o;
        x.pos    = p[2:0];
        x.done   = d;
        x.err    = e;
        exp_q.push_back(x);
    endtask

    // Reference: find the gap lane from the row rules, walk to it one lane at a time, then cross.
    task automatic model_row(input logic [15:0] r, input bit last);
        int n_open, first, gap, typ;
        bit wall, bad;
        n_open = 0; first = -1; wall = 0; bad = 0;
        gap = model_pos; typ = 0;
        for (int i = 0; i < 8; i++) begin
            if (r[2*i +: 2] == 2'd3) wall = 1;
            else begin
                n_open++;
                if (first < 0) first = i;
            end
        end
        if (!wall) begin
            typ = int'(r[2*model_pos +: 2]);
        end else if (n_open == 0) begin
`ifdef FG_ROW_CHECK_EN
            bad = 1;
`else
            gap = model_pos;
            typ = 0;
`endif
        end else begin
`ifdef FG_ROW_CHECK_EN
            bad = (n_open != 1);
`endif
            gap = first;
            typ = int'(r[2*first +: 2]);
        end
        if (bad) begin
            push_exp(1, 2'd0, 0, last, 1);
            return;
        end
        while (model_pos != gap) begin
            if (gap > model_pos) begin
                model_pos++;
                push_exp(0, 2'd1, model_pos, 0, 0);
            end else begin
                model_pos--;
                push_exp(0, 2'd2, model_pos, 0, 0);
            end
        end
        push_exp(0, (typ == 1) ? 2'd3 : 2'd0, model_pos, 0, 0);
        if (last) push_exp(1, 2'd0, 0, 1, 0);
    endtask

    function automatic logic [15:0] wall_row(input int g, input logic [1:0] t);
        logic [15:0] r;
        r = '1;
        r[2*g +: 2] = t;
        return r;
    endfunction

    function automatic logic [15:0] rand_row();
        logic [15:0] r;
        int k, g, g2;
        k = $urandom_range(0, 9);
        r = '1;
        if (k <= 3) begin
            for (int i = 0; i < 8; i++) r[2*i +: 2] = 2'($urandom_range(0, 2));
        end else if (k <= 8) begin
            g = $urandom_range(0, 7);
            r[2*g +: 2] = 2'($urandom_range(0, 2));
        end else if ($urandom_range(0, 1) == 1) begin
            g  = $urandom_range(0, 7);
            g2 = (g + $urandom_range(1, 7)) % 8;
            r[2*g +: 2]  = 2'($urandom_range(0, 2));
            r[2*g2 +: 2] = 2'($urandom_range(0, 2));
        end
        return r;
    endfunction

    // Monitor: every presented move or done/err pulse consumes one scoreboard entry.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            if (!out_valid) check("out_zero_when_idle", {30'd0, out}, 32'd0);
            if (out_valid) begin
                if (exp_q.size() == 0) check("unexpected_move", {31'd0, out_valid}, 32'd0);
                else begin
                    e = exp_q.pop_front();
                    if (e.is_evt) check("move_instead_of_event", {31'd0, out_valid}, 32'd0);
                    else check("move_out_pos", {27'd0, out, pos}, {27'd0, e.out, e.pos});
                end
            end
            if (done || err) begin
                if (exp_q.size() == 0) check("unexpected_done_err", {30'd0, done, err}, 32'd0);
                else begin
                    e = exp_q.pop_front();
                    if (!e.is_evt) check("event_instead_of_move", {30'd0, done, err}, 32'd0);
                    else check("done_err", {30'd0, done, err}, {30'd0, e.done, e.err});
                end
            end
        end
    end

    task automatic apply_reset(input int n);
        rst_n    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        exp_q.delete();
    endtask

    task automatic start_session(input bit [2:0] g);
        guy       = g;
        start     = 1'b1;
        model_pos = g;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic push_row(input logic [15:0] r, input bit last);
        int budget;
        row_drv  = r;
        in_last  = last;
        in_valid = 1'b1;
        budget   = 300;
        while (!in_ready && budget > 0) begin
            @(posedge clk);
            #1;
            budget--;
            stall_cycles++;
        end
        if (!in_ready) begin
            check("push_accept_timeout", {31'd0, in_ready}, 32'd1);
            in_valid = 1'b0;
            return;
        end
        model_row(r, last);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int budget;
        budget = 3000;
        while ((busy || exp_q.size() != 0) && budget > 0) begin
            @(posedge clk);
            #1;
            budget--;
        end
        if (busy || exp_q.size() != 0) begin
            check({name, "_drain_busy"}, {31'd0, busy}, 32'd0);
            check({name, "_drain_pending"}, exp_q.size(), 32'd0);
            apply_reset(2);
            rst_n = 1'b0;
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] r;
        int n_rows;

        rst_n = 1'b1; start = 1'b0; guy = '0;
        in_valid = 1'b0; in_last = 1'b0; row_drv = '0;
        apply_reset(3);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out",       {30'd0, out}, 32'd0);
        check("rst_pos",       {29'd0, pos}, 32'd0);
        check("rst_busy",      {31'd0, busy}, 32'd0);
        check("rst_done",      {31'd0, done}, 32'd0);
        check("rst_err",       {31'd0, err}, 32'd0);
        check("rst_in_ready",  {31'd0, in_ready}, 32'd0);
        rst_n = 1'b0;

        // Walk right to a wall gap, with push-to-move latency measured.
        start_session(3'd2);
        @(posedge clk); #1;
        check("t2_fetch_empty_no_out", {31'd0, out_valid}, 32'd0);
        push_row(wall_row(5, 2'd0), 1'b1);
        check("t2_latency_t1", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        check("t2_latency_t2", {31'd0, out_valid}, 32'd1);
        wait_idle("t2");
        check("t2_final_pos", {29'd0, pos}, 32'd5);

        // Open row, low obstacle under the guy: single jump.
        start_session(3'd4);
        r = '0;
        r[9:8] = 2'd1;
        push_row(r, 1'b1);
        wait_idle("t3");
        check("t3_final_pos", {29'd0, pos}, 32'd4);

        // Long first move while five more rows are pushed back to back.
        start_session(3'd0);
        stall_cycles = 0;
        push_row(wall_row(7, 2'($urandom_range(0, 2))), 1'b0);
        for (int i = 0; i < 5; i++) push_row(wall_row($urandom_range(0, 7), 2'($urandom_range(0, 2))), i == 4);
        check("t4_backpressure_seen", {31'd0, (stall_cycles > 0)}, 32'd1);
        wait_idle("t4");

        // Two-gap wall row, then a normal row; then an all-wall final row.
        start_session(3'd3);
        r = '1;
        r[3:2]   = 2'd0;
        r[13:12] = 2'd0;
        push_row(r, 1'b0);
        push_row(wall_row(2, 2'd2), 1'b1);
        wait_idle("t5a");
        start_session(3'd5);
        push_row(16'hFFFF, 1'b1);
        wait_idle("t5b");

        // Start pulsed mid-move must not disturb the sequence.
        start_session(3'd0);
        push_row(wall_row(6, 2'd1), 1'b1);
        repeat (2) @(posedge clk);
        #1;
        guy = 3'd7; start = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle("t6");
        check("t6_final_pos", {29'd0, pos}, 32'd6);

        // Reset mid-move with a row still buffered.
        start_session(3'd1);
        push_row(wall_row(7, 2'd0), 1'b0);
        push_row(wall_row(0, 2'd1), 1'b1);
        repeat (2) @(posedge clk);
        #1;
        apply_reset(2);
        check("t1_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("t1_rst_pos",       {29'd0, pos}, 32'd0);
        check("t1_rst_busy",      {31'd0, busy}, 32'd0);
        check("t1_rst_in_ready",  {31'd0, in_ready}, 32'd0);
        rst_n = 1'b0;
        start_session(3'd3);
        repeat (4) @(posedge clk);
        #1;
        check("t1_fifo_flushed", {31'd0, out_valid}, 32'd0);
        push_row(wall_row(4, 2'd1), 1'b1);
        wait_idle("t1");

        // Random sessions.
        for (int s = 0; s < 40; s++) begin
            start_session(3'($urandom_range(0, 7)));
            n_rows = $urandom_range(1, 6);
            for (int k = 0; k < n_rows; k++) begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
                push_row(rand_row(), k == n_rows - 1);
            end
            wait_idle("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
